// File: rtl/adc128s_spi_master_pkg.sv
// Shared types and constants for the ADC128S SPI conversion master.
package adc_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRONT,
        ST_SHIFT,
        ST_BACK,
        ST_DONE
    } state_t;

    localparam int unsigned WORD_LEN   = 16;
    localparam int unsigned RESULT_W   = 12;
    localparam int unsigned CH_W       = 3;
    localparam int unsigned BACK_PORCH = 8;

    // Control word: two don't-care bits, channel address, then zero padding.
    function automatic logic [WORD_LEN-1:0] cmd_word(input logic [CH_W-1:0] ch);
        return {2'b00, ch, 11'b0};
    endfunction

endpackage

// File: rtl/adc128s_spi_master_if.sv
// Control-side and ADC-pin signals of the conversion master, grouped as one bundle.
interface adc128s_spi_master_if;
    import adc_spi_pkg::*;

    logic [CH_W-1:0]     channel;
    logic                start_cnv;
    logic [RESULT_W-1:0] result;
    logic                cnv_complete;
    logic                MISO;
    logic                MOSI;
    logic                SCLK;
    logic                SS_n;

    modport master (
        input  channel, start_cnv, MISO,
        output result, cnv_complete, MOSI, SCLK, SS_n
    );

    modport slave (
        output channel, start_cnv, MISO,
        input  result, cnv_complete, MOSI, SCLK, SS_n
    );

endinterface

// File: rtl/adc128s_spi_master_xfer16.sv
// Single 16-bit SPI transaction engine: SCLK divider, TX/RX shift registers, done strobe.
module spi_xfer16
    import adc_spi_pkg::*;
#(
    parameter int unsigned SCLK_DIV_LOG2 = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [WORD_LEN-1:0] i_tx,
    input  logic                i_miso,
    output logic                o_sclk,
    output logic                o_mosi,
    output logic                o_done,
    output logic [WORD_LEN-1:0] o_rx
);
    localparam int unsigned       BIT_W        = $clog2(WORD_LEN);
    localparam logic [SCLK_DIV_LOG2-1:0] DIV_LAST     = '1;
    localparam logic [SCLK_DIV_LOG2-1:0] DIV_PRE_RISE = DIV_LAST >> 1;
    localparam logic [BIT_W-1:0]  BIT_LAST     = BIT_W'(WORD_LEN - 1);

    logic                     r_active;
    logic                     r_sclk;
    logic [SCLK_DIV_LOG2-1:0] r_div;
    logic [BIT_W-1:0]         r_bit;
    logic [WORD_LEN-1:0]      r_tx;
    logic [WORD_LEN-1:0]      r_rx;
    logic [SCLK_DIV_LOG2-1:0] w_div_nxt;

    assign w_div_nxt = r_div + SCLK_DIV_LOG2'(1);
    assign o_done    = r_active && (r_div == DIV_LAST) && (r_bit == BIT_LAST);
    assign o_sclk    = r_sclk;
    assign o_mosi    = r_tx[WORD_LEN-1];
    assign o_rx      = r_rx;

    // SCLK is registered from the next divider MSB: low for the first half-period, high for the second.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_sclk   <= 1'b1;
            r_div    <= '0;
            r_bit    <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_sclk   <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
            r_tx     <= i_tx;
            r_rx     <= '0;
        end else if (r_active) begin
            r_div  <= w_div_nxt;
            r_sclk <= w_div_nxt[SCLK_DIV_LOG2-1];
            if (r_div == DIV_PRE_RISE) begin
                r_rx <= {r_rx[WORD_LEN-2:0], i_miso};
            end
            if (r_div == DIV_LAST) begin
                if (r_bit == BIT_LAST) begin
                    r_active <= 1'b0;
                    r_sclk   <= 1'b1;
                    r_tx     <= '0;
                end else begin
                    r_bit <= r_bit + BIT_W'(1);
                    r_tx  <= {r_tx[WORD_LEN-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/adc128s_spi_master.sv
// Sequences two SPI frames per conversion (address, then address + capture) and holds the result.
module adc128s_spi_master
    import adc_spi_pkg::*;
#(
    parameter int unsigned SCLK_DIV_LOG2 = 5,
    parameter int unsigned FRONT_PORCH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adc128s_spi_master_if.master bus
);
    localparam int unsigned      PORCH_MAX  = (FRONT_PORCH > BACK_PORCH) ? FRONT_PORCH : BACK_PORCH;
    localparam int unsigned      CNT_W      = $clog2(PORCH_MAX + 1);
    localparam logic [CNT_W-1:0] FRONT_LAST = CNT_W'(FRONT_PORCH - 1);
    localparam logic [CNT_W-1:0] BACK_LAST  = CNT_W'(BACK_PORCH - 1);

    state_t                      r_state;
    state_t                      w_next;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_pass;
    logic [CH_W-1:0]             r_ch;
    logic [RESULT_W-1:0]         r_result;
    logic                        r_complete;
    logic                        r_ss_n;
    logic                        w_xfer_start;
    logic                        w_xfer_done;
    logic                        w_sclk;
    logic                        w_mosi;
    logic [WORD_LEN-1:0]         w_rx;
    logic [RESULT_W-1:0]         w_rx_data;
    logic [WORD_LEN-RESULT_W-1:0] w_lead_unused;

    // The ADC's leading zero bits are dropped.
    assign {w_lead_unused, w_rx_data} = w_rx;
    assign w_xfer_start = (r_state == ST_FRONT) && (r_cnt == FRONT_LAST);

    spi_xfer16 #(
        .SCLK_DIV_LOG2(SCLK_DIV_LOG2)
    ) u_xfer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_start(w_xfer_start),
        .i_tx   (cmd_word(r_ch)),
        .i_miso (bus.MISO),
        .o_sclk (w_sclk),
        .o_mosi (w_mosi),
        .o_done (w_xfer_done),
        .o_rx   (w_rx)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (bus.start_cnv) w_next = ST_FRONT;
            ST_FRONT: if (r_cnt == FRONT_LAST) w_next = ST_SHIFT;
            ST_SHIFT: if (w_xfer_done) w_next = ST_BACK;
            ST_BACK:  if (r_cnt == BACK_LAST) w_next = r_pass ? ST_DONE : ST_FRONT;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pass     <= 1'b0;
            r_ch       <= '0;
            r_result   <= '0;
            r_complete <= 1'b0;
            r_ss_n     <= 1'b1;
        end else begin
            r_state <= w_next;
            // Select decoded from the next state so SS_n switches on the same edge as the state.
            r_ss_n  <= !((w_next == ST_FRONT) || (w_next == ST_SHIFT));
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == ST_FRONT) || (r_state == ST_BACK)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == ST_IDLE) && bus.start_cnv) begin
                r_ch       <= bus.channel;
                r_complete <= 1'b0;
                r_pass     <= 1'b0;
            end
            if ((r_state == ST_BACK) && (r_cnt == BACK_LAST)) begin
                r_pass <= 1'b1;
            end
            if (r_state == ST_DONE) begin
                r_result   <= w_rx_data;
                r_complete <= 1'b1;
            end
        end
    end

    assign bus.result       = r_result;
    assign bus.cnv_complete = r_complete;
    assign bus.SS_n         = r_ss_n;
    assign bus.SCLK         = w_sclk;
    assign bus.MOSI         = w_mosi;

endmodule

// File: tb/tb_adc128s_spi_master.sv
// Scoreboard bench for adc128s_spi_master with a behavioural ADC128S model on the SPI pins.
module tb_adc128s_spi_master;

    typedef struct {
        logic [11:0] res;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adc128s_spi_master_if bus_if();

    adc128s_spi_master #(
        .SCLK_DIV_LOG2(5),
        .FRONT_PORCH  (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned n_started = 0;
    int unsigned n_completed = 0;
    int unsigned n_aborted = 0;
    int unsigned abort_req = 0;
    int unsigned abort_seen = 0;
    int unsigned frames = 0;
    exp_t        exp_q[$];
    logic [15:0] mosi_q[$];
    logic [11:0] ch_val[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit busy();
        return n_started != (n_completed + n_aborted);
    endfunction

    function automatic logic [15:0] cmd(input logic [2:0] ch);
        return 16'(ch) << 11;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Completion monitor: pops the scoreboard on each rising cnv_complete.
    logic prev_cc = 1'b0;
    exp_t e_pop;
    always @(negedge clk) begin
        if (bus_if.cnv_complete === 1'b1 && !prev_cc) begin
            if (exp_q.size() == 0) begin
                check("unexpected_complete", 1, 0);
            end else begin
                e_pop = exp_q.pop_front();
                check("result", 32'(bus_if.result), 32'(e_pop.res));
                check("complete_cycle", cyc, e_pop.cyc);
                n_completed++;
            end
        end
        prev_cc = (bus_if.cnv_complete === 1'b1);
    end

    // ADC128S model plus frame monitor, evaluated on pin edges seen at the falling clk edge.
    logic        prev_ss = 1'b1;
    logic        prev_sclk = 1'b1;
    logic [15:0] out_word = '0;
    logic [15:0] din = '0;
    logic [2:0]  adc_addr = '0;
    logic [2:0]  cur_addr = '0;
    logic [3:0]  oidx;
    int unsigned falls = 0;
    int unsigned rises = 0;
    int unsigned idle_low = 0;
    always @(negedge clk) begin
        if (prev_ss && !bus_if.SS_n) begin
            check("idle_sclk_low", idle_low, 0);
            idle_low = 0;
            out_word = {4'b0000, ch_val[adc_addr]};
            falls = 0;
            rises = 0;
            din = '0;
            cur_addr = adc_addr;
        end
        if (bus_if.SS_n && !bus_if.SCLK) idle_low++;
        if (bus_if.SS_n) begin
            bus_if.MISO = 1'b0;
        end else begin
            if (prev_sclk && !bus_if.SCLK) begin
                if (falls < 16) begin
                    oidx = 4'(15 - falls);
                    bus_if.MISO = out_word[oidx];
                end
                falls++;
            end
            if (!prev_sclk && bus_if.SCLK) begin
                din = {din[14:0], bus_if.MOSI};
                rises++;
                if (rises == 5) cur_addr = din[2:0];
            end
        end
        if (!prev_ss && bus_if.SS_n) begin
            adc_addr = cur_addr;
            if (abort_req != abort_seen) begin
                abort_seen = abort_req;
            end else begin
                frames++;
                check("frame_rises", rises, 16);
                check("frame_falls", falls, 16);
                if (mosi_q.size() == 0) check("unexpected_frame", 1, 0);
                else check("mosi_word", 32'(din), 32'(mosi_q.pop_front()));
            end
        end
        prev_ss = bus_if.SS_n;
        prev_sclk = bus_if.SCLK;
    end

    // Call at a falling clk edge; the pulse is sampled on the following rising edge.
    task automatic start(input logic [2:0] ch);
        exp_t e;
        bus_if.channel = ch;
        bus_if.start_cnv = 1'b1;
        if (!busy()) begin
            e.res = ch_val[ch];
            e.cyc = cyc + 1058;
            exp_q.push_back(e);
            mosi_q.push_back(cmd(ch));
            mosi_q.push_back(cmd(ch));
            n_started++;
        end
        @(negedge clk);
        bus_if.start_cnv = 1'b0;
    endtask

    task automatic wait_done();
        int unsigned n = 0;
        while (busy() && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(busy()), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned f0;
        int unsigned c0;
        logic [2:0]  rch;
        bus_if.channel = '0;
        bus_if.start_cnv = 1'b0;
        for (int i = 0; i < 8; i++) ch_val[i] = 12'($urandom);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ss_n", 32'(bus_if.SS_n), 1);
        check("rst_sclk", 32'(bus_if.SCLK), 1);
        check("rst_mosi", 32'(bus_if.MOSI), 0);
        check("rst_result", 32'(bus_if.result), 0);
        check("rst_complete", 32'(bus_if.cnv_complete), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Channel 1 with a fixed model value.
        ch_val[1] = 12'hC35;
        start(3'd1);
        wait_done();
        check("ch1_result", 32'(bus_if.result), 32'h0C35);
        check("ch1_complete", 32'(bus_if.cnv_complete), 1);

        // Channel 7: frame shape is checked by the monitor.
        start(3'd7);
        wait_done();

        // A start pulse mid-conversion is ignored.
        f0 = frames;
        c0 = n_completed;
        start(3'd2);
        repeat (298) @(negedge clk);
        start(3'd6);
        wait_done();
        repeat (1200) @(negedge clk);
        check("ignored_start_frames", frames - f0, 2);
        check("ignored_start_completions", n_completed - c0, 1);
        check("ignored_start_ss_idle", 32'(bus_if.SS_n), 1);

        // Back-to-back conversions; cnv_complete drops on the second start.
        ch_val[0] = 12'h001;
        ch_val[5] = 12'hFFE;
        start(3'd0);
        wait_done();
        check("b2b_complete_before", 32'(bus_if.cnv_complete), 1);
        start(3'd5);
        check("b2b_complete_dropped", 32'(bus_if.cnv_complete), 0);
        wait_done();
        check("b2b_result_ch5", 32'(bus_if.result), 32'h0FFE);

        // Reset during the second frame, then a normal conversion.
        start(3'd3);
        repeat (700) @(negedge clk);
        abort_req++;
        exp_q.delete();
        mosi_q.delete();
        n_aborted++;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ss_n", 32'(bus_if.SS_n), 1);
        check("midrst_sclk", 32'(bus_if.SCLK), 1);
        check("midrst_result", 32'(bus_if.result), 0);
        check("midrst_complete", 32'(bus_if.cnv_complete), 0);
        rst_n = 1'b1;
        @(negedge clk);
        start(3'd4);
        wait_done();

        // Channel input changed mid-conversion has no effect.
        ch_val[6] = 12'h5A6;
        ch_val[1] = 12'h3C3;
        start(3'd6);
        repeat (400) @(negedge clk);
        bus_if.channel = 3'd1;
        wait_done();
        check("chg_result", 32'(bus_if.result), 32'h05A6);

        // Randomised conversions with random mid-conversion channel noise.
        for (int k = 0; k < 4; k++) begin
            rch = 3'($urandom_range(0, 7));
            ch_val[rch] = 12'($urandom);
            start(rch);
            repeat ($urandom_range(1, 900)) @(negedge clk);
            bus_if.channel = 3'($urandom);
            wait_done();
        end
        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size() + mosi_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
